// File: rtl/snake_dir_ctrl_if.sv
// Bundle of key levels, game pulses and direction outputs shared between the
// PS2 decoder side (master) and the direction scheduler (slave).
interface snake_dir_ctrl_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       step;
    logic       restart;
    logic [1:0] dir;
    logic       turn;
    logic       drop;
    logic [2:0] q_count;

    modport master (
        output up, down, left, right, step, restart,
        input  dir, turn, drop, q_count
    );

    modport slave (
        input  up, down, left, right, step, restart,
        output dir, turn, drop, q_count
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns held-key levels into queued, legal snake turns and
// commits one turn per game step.
// Optional feature macro: SNAKE_DIR_QUEUE_EN -- when defined a QDEPTH-entry
// FIFO holds pending turns; when undefined a single last-wins pending slot is
// used and QDEPTH has no effect.
// Direction encoding: 0 up, 1 down, 2 left, 3 right. Opposite = flip bit 0.
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input logic             clk,
    input logic             rst,
    snake_dir_ctrl_if.slave bus
);

    if (QDEPTH < 1 || QDEPTH > 4) begin : g_qdepth_chk
        $error("snake_dir_ctrl: QDEPTH must be within 1..4");
    end

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    // bit k of keys corresponds to direction code k
    logic [3:0] keys;
    logic [3:0] prev_q;
    logic [3:0] press;
    logic       win_vld;
    logic [1:0] win_dir;
    logic       loser;

    logic [1:0] dir_q;
    logic       turn_q;
    logic       drop_q;

    assign keys    = {bus.right, bus.left, bus.down, bus.up};
    assign press   = keys & ~prev_q;
    assign win_vld = |press;
    assign loser   = |(press & (press - 4'd1));

    // Fixed-priority arbitration among simultaneous presses: up > down > left > right.
    always_comb begin
        win_dir = 2'd3;
        if (press[0])      win_dir = 2'd0;
        else if (press[1]) win_dir = 2'd1;
        else if (press[2]) win_dir = 2'd2;
    end

`ifdef SNAKE_DIR_QUEUE_EN
    localparam int             PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0]  LAST = PW'(QDEPTH - 1);
    localparam logic [2:0]     CAP  = 3'(QDEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [1:0]    mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [2:0]    count_q;
    logic [PW-1:0] tail_ptr;
    logic [1:0]    ref_dir;
    logic          pop;
    logic          full_after_pop;
    logic          push;
    logic          reject;

    // Reference is the newest queued turn (or dir when empty), taken before any pop.
    always_comb begin
        tail_ptr       = (wr_ptr_q == '0) ? LAST : wr_ptr_q - 1'b1;
        ref_dir        = (count_q != 3'd0) ? mem_q[tail_ptr] : dir_q;
        pop            = bus.step && (count_q != 3'd0);
        full_after_pop = (count_q - 3'(pop)) == CAP;
        push           = win_vld && (win_dir != ref_dir) &&
                         (win_dir != opposite(ref_dir)) && !full_after_pop;
        reject         = win_vld && (win_dir != ref_dir) &&
                         ((win_dir == opposite(ref_dir)) || full_after_pop);
    end

    // Key history, FIFO pointers/contents and registered outputs; restart flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q   <= 4'd0;
            dir_q    <= INIT_DIR;
            turn_q   <= 1'b0;
            drop_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= 2'd0;
        end else begin
            prev_q <= keys;
            turn_q <= 1'b0;
            drop_q <= loser;
            if (bus.restart) begin
                dir_q    <= INIT_DIR;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= 3'd0;
            end else begin
                if (pop) begin
                    dir_q    <= mem_q[rd_ptr_q];
                    turn_q   <= (mem_q[rd_ptr_q] != dir_q);
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                if (push) begin
                    mem_q[wr_ptr_q] <= win_dir;
                    wr_ptr_q        <= ptr_inc(wr_ptr_q);
                end
                count_q <= count_q - 3'(pop) + 3'(push);
                drop_q  <= loser | reject;
            end
        end
    end

    assign bus.q_count = count_q;
`else
    logic       pend_vld_q;
    logic [1:0] pend_q;
    logic       pop;
    logic       push;
    logic       reject;

    // Legality is judged against the committed direction, not the pending slot.
    always_comb begin
        pop    = bus.step && pend_vld_q;
        push   = win_vld && (win_dir != dir_q) && (win_dir != opposite(dir_q));
        reject = win_vld && (win_dir == opposite(dir_q));
    end

    // Key history, last-wins pending slot and registered outputs; restart clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= 4'd0;
            dir_q      <= INIT_DIR;
            turn_q     <= 1'b0;
            drop_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= 2'd0;
        end else begin
            prev_q <= keys;
            turn_q <= 1'b0;
            drop_q <= loser;
            if (bus.restart) begin
                dir_q      <= INIT_DIR;
                pend_vld_q <= 1'b0;
            end else begin
                if (pop) begin
                    dir_q  <= pend_q;
                    turn_q <= (pend_q != dir_q);
                end
                if (push) begin
                    pend_q <= win_dir;
                end
                pend_vld_q <= push | (pend_vld_q & ~pop);
                drop_q     <= loser | reject;
            end
        end
    end

    assign bus.q_count = {2'b00, pend_vld_q};
`endif

    assign bus.dir  = dir_q;
    assign bus.turn = turn_q;
    assign bus.drop = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus randomized key/step/restart
// traffic compared each cycle against a queue-based behavioural model.
module tb_snake_dir_ctrl;
    localparam int         QDEPTH   = 2;
    localparam logic [1:0] INIT_DIR = 2'd3;
`ifdef SNAKE_DIR_QUEUE_EN
    localparam bit QMODE = 1'b1;
    localparam int CAP   = QDEPTH;
`else
    localparam bit QMODE = 1'b0;
    localparam int CAP   = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    snake_dir_ctrl_if bus();

    snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(INIT_DIR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // behavioural model state
    int m_dir;
    int m_q[$];
    bit m_prev[4];
    bit m_turn;
    bit m_drop;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = INIT_DIR;
        m_q.delete();
        for (int k = 0; k < 4; k++) m_prev[k] = 1'b0;
        m_turn = 1'b0;
        m_drop = 1'b0;
    endtask

    // One clock edge of the scheduler, from the rules in plain arithmetic.
    task automatic model_edge(input bit [3:0] keys, input bit st, input bit rs);
        int n;
        int w;
        int refd;
        int old;
        n = 0;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (keys[k] && !m_prev[k]) begin
                n++;
                if (w < 0) w = k;
            end
        end
        m_turn = 1'b0;
        m_drop = (n > 1);
        refd = (QMODE && m_q.size() > 0) ? m_q[$] : m_dir;
        if (rs) begin
            m_q.delete();
            m_dir = INIT_DIR;
        end else begin
            old = m_dir;
            if (st && m_q.size() > 0) begin
                m_dir  = m_q.pop_front();
                m_turn = (m_dir != old);
            end
            if (w >= 0 && w != refd) begin
                if (w == (refd ^ 1)) m_drop = 1'b1;
                else if (!QMODE) begin
                    m_q.delete();
                    m_q.push_back(w);
                end else if (m_q.size() < CAP) m_q.push_back(w);
                else m_drop = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) m_prev[k] = keys[k];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dir"},     8'(bus.dir),     8'(m_dir));
        chk({tag, ".turn"},    8'(bus.turn),    8'(m_turn));
        chk({tag, ".drop"},    8'(bus.drop),    8'(m_drop));
        chk({tag, ".q_count"}, 8'(bus.q_count), 8'(m_q.size()));
    endtask

    task automatic cyc(input bit u, input bit d, input bit l, input bit r,
                       input bit st, input bit rs, input string tag);
        bus.up = u; bus.down = d; bus.left = l; bus.right = r;
        bus.step = st; bus.restart = rs;
        @(posedge clk);
        model_edge({r, l, d, u}, st, rs);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0;
        bus.step = 0; bus.restart = 0;
        @(posedge clk);
        #1;
        check_all("areset_hold");
        rst = 1'b1;
    endtask

    initial begin
        bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0;
        bus.step = 0; bus.restart = 0;
        model_reset();

        // reset asserted and held
        #2 rst = 1'b0;
        #1 check_all("reset_async");
        chk("reset.dir_const", 8'(bus.dir), 8'd3);
        repeat (3) @(posedge clk);
        #1 check_all("reset_held");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, "idle");
        chk("idle.dir_const", 8'(bus.dir), 8'd3);

        // single press then step
        cyc(1, 0, 0, 0, 0, 0, "press_up");
        chk("press_up.q1", 8'(bus.q_count), 8'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, "wait");
        cyc(0, 0, 0, 0, 1, 0, "step_up");
        chk("step_up.dir0", 8'(bus.dir), 8'd0);
        chk("step_up.turn1", 8'(bus.turn), 8'd1);
        chk("step_up.q0", 8'(bus.q_count), 8'd0);
        cyc(0, 0, 0, 0, 0, 0, "after_step");
        chk("after_step.turn0", 8'(bus.turn), 8'd0);

        // reversal rejection
        cyc(0, 0, 0, 0, 0, 1, "restart1");
        chk("restart1.dir3", 8'(bus.dir), 8'd3);
        cyc(0, 0, 1, 0, 0, 0, "reverse");
        chk("reverse.drop1", 8'(bus.drop), 8'd1);
        chk("reverse.dir3", 8'(bus.dir), 8'd3);
        chk("reverse.q0", 8'(bus.q_count), 8'd0);
        cyc(0, 0, 0, 0, 0, 0, "reverse_after");
        chk("reverse_after.drop0", 8'(bus.drop), 8'd0);

        // queue fill and drain
        cyc(1, 0, 0, 0, 0, 0, "qf_up");
        cyc(0, 0, 0, 0, 0, 0, "qf_rel");
        cyc(0, 0, 1, 0, 0, 0, "qf_left");
        cyc(0, 0, 0, 0, 0, 0, "qf_rel");
        cyc(0, 1, 0, 0, 0, 0, "qf_down");
`ifdef SNAKE_DIR_QUEUE_EN
        chk("qf_down.q2", 8'(bus.q_count), 8'd2);
        chk("qf_down.drop1", 8'(bus.drop), 8'd1);
`endif
        cyc(0, 0, 0, 0, 1, 0, "qf_step1");
`ifdef SNAKE_DIR_QUEUE_EN
        chk("qf_step1.dir0", 8'(bus.dir), 8'd0);
`endif
        cyc(0, 0, 0, 0, 1, 0, "qf_step2");
`ifdef SNAKE_DIR_QUEUE_EN
        chk("qf_step2.dir2", 8'(bus.dir), 8'd2);
`endif

        // simultaneous presses
        cyc(0, 0, 0, 0, 0, 1, "restart2");
        cyc(1, 0, 1, 0, 0, 0, "simul");
        chk("simul.q1", 8'(bus.q_count), 8'd1);
        chk("simul.drop1", 8'(bus.drop), 8'd1);

        // restart colliding with step while turns are queued
        cyc(0, 0, 0, 0, 0, 1, "restart3");
        cyc(1, 0, 0, 0, 0, 0, "rc_up");
        cyc(0, 0, 0, 0, 1, 0, "rc_step");
        cyc(0, 0, 1, 0, 0, 0, "rc_left");
        cyc(0, 0, 0, 0, 0, 0, "rc_rel");
        cyc(0, 1, 0, 0, 0, 0, "rc_down");
`ifdef SNAKE_DIR_QUEUE_EN
        chk("rc_down.q2", 8'(bus.q_count), 8'd2);
        chk("rc_down.dir0", 8'(bus.dir), 8'd0);
`endif
        cyc(0, 0, 0, 0, 1, 1, "rc_collide");
        chk("rc_collide.dir3", 8'(bus.dir), 8'd3);
        chk("rc_collide.q0", 8'(bus.q_count), 8'd0);
        chk("rc_collide.turn0", 8'(bus.turn), 8'd0);

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset();
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
